// File: rtl/up_counter.sv
// Free-running registered step counter: cycles 0..MAX_COUNT, then wraps to 0 or saturates.
// Counter is driven straight from the state register.
module up_counter #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned MAX_COUNT   = 7,
  parameter int unsigned RESET_VALUE = 0,
  parameter int unsigned WRAP        = 1
) (
  input  logic             CLK,
  input  logic             Reset,
  output logic [WIDTH-1:0] Counter
);

  // Parameter sanity: stop elaboration on impossible configurations
  if (WIDTH < 1) begin : g_chk_width
    $error("up_counter: WIDTH must be at least 1");
  end
  if (64'(MAX_COUNT) > ((64'd1 << WIDTH) - 64'd1)) begin : g_chk_max
    $error("up_counter: MAX_COUNT does not fit in WIDTH bits");
  end
  if (RESET_VALUE > MAX_COUNT) begin : g_chk_rst
    $error("up_counter: RESET_VALUE must not exceed MAX_COUNT");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);

  // Declaration initialiser gives a defined power-up value in simulation only
  logic [WIDTH-1:0] count_q = RST_V;
  logic [WIDTH-1:0] count_d;

  // Next count; anything above MAX_V is unreachable and recovers to zero
  always_comb begin
    count_d = '0;
    if (count_q < MAX_V) begin
      count_d = count_q + WIDTH'(1);
    end else if ((count_q == MAX_V) && (WRAP == 0)) begin
      count_d = MAX_V;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      count_q <= RST_V;
    end else begin
      count_q <= count_d;
    end
  end

  assign Counter = count_q;

endmodule

// File: tb/tb_up_counter.sv
// Bench for up_counter: four parameterisations share one clock and reset,
// checked by a vector table, hand-written async-reset sequence and a random reset model.
module tb_up_counter;

  logic       CLK   = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] c0, c1, c2, c3;

  always #5 CLK = ~CLK;

  // dut0 defaults, dut1 full-range wrap, dut2 saturating, dut3 non-zero reset value
  up_counter #(.WIDTH(4), .MAX_COUNT(7),  .RESET_VALUE(0), .WRAP(1)) dut0 (.CLK(CLK), .Reset(Reset), .Counter(c0));
  up_counter #(.WIDTH(4), .MAX_COUNT(15), .RESET_VALUE(0), .WRAP(1)) dut1 (.CLK(CLK), .Reset(Reset), .Counter(c1));
  up_counter #(.WIDTH(4), .MAX_COUNT(7),  .RESET_VALUE(0), .WRAP(0)) dut2 (.CLK(CLK), .Reset(Reset), .Counter(c2));
  up_counter #(.WIDTH(4), .MAX_COUNT(7),  .RESET_VALUE(3), .WRAP(1)) dut3 (.CLK(CLK), .Reset(Reset), .Counter(c3));

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic rst;
    int   e0, e1, e2, e3;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [3:0] act, input int exp);
    total++;
    if (act === 4'(exp)) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: value after n counting edges since reset, from the configuration alone
  function automatic int model(input int k, input int n);
    int m, rv;
    bit w;
    m  = (k == 1) ? 15 : 7;
    rv = (k == 3) ? 3 : 0;
    w  = (k != 2);
    if (w) return (rv + n) % (m + 1);
    return ((rv + n) > m) ? m : (rv + n);
  endfunction

  function automatic logic [3:0] dut_val(input int k);
    case (k)
      0:       return c0;
      1:       return c1;
      2:       return c2;
      default: return c3;
    endcase
  endfunction

  task automatic check_model(input string tag, input int n);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_dut%0d_n%0d", tag, k, n), dut_val(k), model(k, n));
    end
  endtask

  initial begin
    int n;
    logic r;

    // Expected columns: n%8, n%16, min(n,7), (3+n)%8 with n = edges since release
    vecs[0]  = '{1'b0, 0, 0, 0, 3};
    vecs[1]  = '{1'b0, 0, 0, 0, 3};
    vecs[2]  = '{1'b1, 1, 1, 1, 4};
    vecs[3]  = '{1'b1, 2, 2, 2, 5};
    vecs[4]  = '{1'b1, 3, 3, 3, 6};
    vecs[5]  = '{1'b1, 4, 4, 4, 7};
    vecs[6]  = '{1'b1, 5, 5, 5, 0};
    vecs[7]  = '{1'b1, 6, 6, 6, 1};
    vecs[8]  = '{1'b1, 7, 7, 7, 2};
    vecs[9]  = '{1'b1, 0, 8, 7, 3};
    vecs[10] = '{1'b1, 1, 9, 7, 4};
    vecs[11] = '{1'b1, 2, 10, 7, 5};
    vecs[12] = '{1'b1, 3, 11, 7, 6};
    vecs[13] = '{1'b1, 4, 12, 7, 7};
    vecs[14] = '{1'b1, 5, 13, 7, 0};
    vecs[15] = '{1'b1, 6, 14, 7, 1};
    vecs[16] = '{1'b1, 7, 15, 7, 2};
    vecs[17] = '{1'b1, 0, 0, 7, 3};
    vecs[18] = '{1'b1, 1, 1, 7, 4};
    vecs[19] = '{1'b1, 2, 2, 7, 5};
    vecs[20] = '{1'b0, 0, 0, 0, 3};
    vecs[21] = '{1'b1, 1, 1, 1, 4};

    // Power-up value before any reset or clock edge
    #1;
    check("powerup_dut0", c0, 0);
    check("powerup_dut3", c3, 3);

    @(negedge CLK);
    for (int i = 0; i < 22; i++) begin
      Reset = vecs[i].rst;
      @(posedge CLK);
      @(negedge CLK);
      check($sformatf("vec%0d_dut0", i), c0, vecs[i].e0);
      check($sformatf("vec%0d_dut1", i), c1, vecs[i].e1);
      check($sformatf("vec%0d_dut2", i), c2, vecs[i].e2);
      check($sformatf("vec%0d_dut3", i), c3, vecs[i].e3);
    end

    // Asynchronous reset at count 5, between edges, then restart
    Reset = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b1;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    check("async_pre_dut0", c0, 5);
    #2 Reset = 1'b0;
    #1;
    check("async_now_dut0", c0, 0);
    check("async_now_dut3", c3, 3);
    check("async_now_dut2", c2, 0);
    #1 Reset = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("async_rel1_dut0", c0, 1);
    @(posedge CLK);
    @(negedge CLK);
    check("async_rel2_dut0", c0, 2);
    check("async_rel2_dut3", c3, 5);

    // Random reset pulses against the reference model
    Reset = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    n = 0;
    check_model("rnd_start", n);
    for (int it = 0; it < 400; it++) begin
      r = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
      Reset = r;
      if (!r) begin
        #1;
        check_model("rnd_async", 0);
      end
      @(posedge CLK);
      n = r ? n + 1 : 0;
      @(negedge CLK);
      check_model("rnd", n);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
